// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversampled SCLK/CS/MOSI, MSB-first word assembly, valid/ready output.
// Define SPI_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  sclk_i,
  input  logic                  cs_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i,
  output logic                  frame_active_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
    $error("spi_slave_rx: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of 2 >= 2");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic sclkPrev_q, csPrev_q, mosiPrev_q;
  logic sclkRise_q, sclkFall_q, csRise_q, csFall_q;
  logic [FLUSH_W-1:0] flushCnt_q;
  logic armed_q;

  state_t                state_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic [DATA_WIDTH-1:0] rxShift_q, txShift_q, replyBuf_q;

  logic                  sclkS, csS, mosiS;
  logic                  wordPush, overrunSet, overrun_q;
  logic [DATA_WIDTH-1:0] wordIn;

  assign sclkS = sclkSync_q[SYNC_STAGES-1];
  assign csS   = csSync_q[SYNC_STAGES-1];
  assign mosiS = mosiSync_q[SYNC_STAGES-1];

  // Synchronisers idle at the bus-idle levels so reset never fabricates an edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sclkSync_q <= '0;
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b1;
      mosiPrev_q <= 1'b0;
      sclkRise_q <= 1'b0;
      sclkFall_q <= 1'b0;
      csRise_q   <= 1'b0;
      csFall_q   <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_i};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_i};
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
      mosiPrev_q <= mosiS;
      sclkRise_q <= sclkS & ~sclkPrev_q;
      sclkFall_q <= ~sclkS & sclkPrev_q;
      csRise_q   <= csS & ~csPrev_q;
      csFall_q   <= ~csS & csPrev_q;
    end
  end

  // A frame may only start after CS has been seen high once the synchronisers hold real pin values,
  // so a CS already low when reset releases cannot masquerade as a falling edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      flushCnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      if (flushCnt_q != FLUSH_DONE) flushCnt_q <= flushCnt_q + FLUSH_W'(1);
      if (flushCnt_q == FLUSH_DONE && csS && csPrev_q) armed_q <= 1'b1;
    end
  end

  assign wordIn   = {rxShift_q[DATA_WIDTH-2:0], mosiPrev_q};
  assign wordPush = (state_q == SHIFT) && !csRise_q && sclkRise_q && (bitCnt_q == LAST_BIT);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      replyBuf_q <= '0;
    end else begin
      if (tx_load_i) replyBuf_q <= tx_data_i;
      case (state_q)
        IDLE: begin
          if (csFall_q && armed_q) begin
            state_q   <= SHIFT;
            bitCnt_q  <= '0;
            txShift_q <= replyBuf_q;
          end
        end
        SHIFT: begin
          if (csRise_q) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
          end else begin
            if (sclkRise_q) begin
              rxShift_q <= wordIn;
              bitCnt_q  <= (bitCnt_q == LAST_BIT) ? '0 : bitCnt_q + CNT_W'(1);
            end
            if (sclkFall_q) begin
              txShift_q <= (bitCnt_q == '0) ? replyBuf_q : {txShift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_active_o = ~csS;
  assign miso_o         = ~csS & txShift_q[DATA_WIDTH-1];

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wrPtr_q, rdPtr_q;
  logic                  fifoEmpty, fifoFull, fifoPop, fifoPush;

  assign fifoEmpty  = (wrPtr_q == rdPtr_q);
  assign fifoFull   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign fifoPop    = !fifoEmpty && rx_ready_i;
  assign fifoPush   = wordPush && (!fifoFull || fifoPop);
  assign overrunSet = wordPush && fifoFull && !fifoPop;
  assign rx_valid_o = !fifoEmpty;
  assign rx_data_o  = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (fifoPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= wordIn;
        wrPtr_q <= wrPtr_q + (AW+1)'(1);
      end
      if (fifoPop) rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end
`else
  logic [DATA_WIDTH-1:0] rxData_q;
  logic                  rxValid_q;

  assign overrunSet = wordPush && rxValid_q && !rx_ready_i;
  assign rx_valid_o = rxValid_q;
  assign rx_data_o  = rxData_q;

  // A completed word may replace the held one only if the consumer takes the old one this cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
    end else if (wordPush && (!rxValid_q || rx_ready_i)) begin
      rxData_q  <= wordIn;
      rxValid_q <= 1'b1;
    end else if (rxValid_q && rx_ready_i) begin
      rxValid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)         overrun_q <= 1'b0;
    else if (overrunSet)    overrun_q <= 1'b1;
    else if (overrun_clr_i) overrun_q <= 1'b0;
  end

  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven single-word frames, directed corner cases,
// and random frames checked against a queue-based model of the SPI link.
module tb_spi_slave_rx;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int FD   = 4;
  localparam int HALF = 6;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = FD;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic reset_n, sclk, cs, mosi, miso, rx_valid, rx_ready, tx_load, overrun, overrun_clr, frame_active;
  logic [DW-1:0] rx_data, tx_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] gotQ[$];

  typedef struct {
    logic [DW-1:0] reply;
    logic [DW-1:0] mosiWord;
    logic [DW-1:0] expRx;
    logic [DW-1:0] expMiso;
  } vec_t;
  vec_t vecs[4];

  spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .sclk_i(sclk), .cs_i(cs), .mosi_i(mosi), .miso_o(miso),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .tx_data_i(tx_data),
    .tx_load_i(tx_load), .overrun_o(overrun), .overrun_clr_i(overrun_clr),
    .frame_active_o(frame_active)
  );

  always #5 clk = ~clk;

  // Consumer side: every accepted handshake lands in gotQ.
  always @(negedge clk) if (reset_n && rx_valid && rx_ready) gotQ.push_back(rx_data);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadReply(input logic [DW-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  // hook: 1 latency check, 2 rx_ready pulse at completion, 3 overrun_clr pulse at completion,
  // 4 tx_load of loadVal during the last bit.
  task automatic spiWord(input logic [DW-1:0] w, output logic [DW-1:0] misoW, input int hook,
                         input logic [DW-1:0] loadVal);
    for (int i = DW - 1; i >= 0; i--) begin
      mosi = w[i];
      tick(HALF);
      misoW[i] = miso;
      sclk = 1'b1;
      if (i == 0 && hook >= 1 && hook <= 3) begin
        tick(SS + 1);
        if (hook == 1) checkOutput("latency_before", rx_valid, 0);
        if (hook == 2) rx_ready = 1'b1;
        if (hook == 3) overrun_clr = 1'b1;
        tick(1);
        if (hook == 1) checkOutput("latency_at", rx_valid, 1);
        rx_ready    = (hook == 2) ? 1'b0 : rx_ready;
        overrun_clr = 1'b0;
        tick(HALF - SS - 2);
      end else if (i == 0 && hook == 4) begin
        tick(1);
        loadReply(loadVal);
        tick(HALF - 2);
      end else begin
        tick(HALF);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic spiBits(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom);
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic endFrame();
    tick(HALF);
    cs = 1'b1;
    tick(2 * HALF);
  endtask

  // One frame of the given words; hook applies to word hookWord only.
  task automatic applyStimulus(input logic [DW-1:0] words[$], input int hookWord, input int hook,
                               input logic [DW-1:0] loadVal, output logic [DW-1:0] misoQ[$]);
    logic [DW-1:0] m;
    misoQ.delete();
    cs = 1'b0;
    foreach (words[k]) begin
      spiWord(words[k], m, (k == hookWord) ? hook : 0, loadVal);
      misoQ.push_back(m);
    end
    endFrame();
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(CAP + 2);
    rx_ready = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [DW-1:0] misoQ[$];
    logic [DW-1:0] words[$];
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] replyModel;
    logic [DW-1:0] m;
    int n;

    reset_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b0;
    tx_load = 1'b0; tx_data = '0; overrun_clr = 1'b0;
    tick(3);
    checkOutput("reset_miso", miso, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_frame_active", frame_active, 0);
    reset_n = 1'b1;
    tick(10);

    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{8'h5A, 8'h81, 8'h81, 8'h5A};
    for (int v = 0; v < 4; v++) begin
      gotQ.delete();
      loadReply(vecs[v].reply);
      words = '{vecs[v].mosiWord};
      applyStimulus(words, 0, (v == 0) ? 1 : 0, 8'h00, misoQ);
      checkOutput($sformatf("vec%0d_rx_valid", v), rx_valid, 1);
      checkOutput($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].expRx);
      checkOutput($sformatf("vec%0d_miso", v), misoQ[0], vecs[v].expMiso);
      checkOutput($sformatf("vec%0d_overrun", v), overrun, 0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      checkOutput($sformatf("vec%0d_popped", v), rx_valid, 0);
      checkOutput($sformatf("vec%0d_single", v), gotQ.size(), 1);
    end

    // Reply buffer change mid-frame takes effect at the next word boundary.
    gotQ.delete();
    loadReply(8'h96);
    rx_ready = 1'b1;
    words = '{8'h01, 8'h02, 8'h03};
    applyStimulus(words, 0, 4, 8'h55, misoQ);
    rx_ready = 1'b0;
    checkOutput("multi_count", gotQ.size(), 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("multi_rx%0d", k), (gotQ.size() > k) ? gotQ[k] : 8'hxx, words[k]);
      checkOutput($sformatf("multi_miso%0d", k), misoQ[k], (k == 0) ? 8'h96 : 8'h55);
    end

    // Overrun when the output stage is full and nobody reads.
    gotQ.delete();
    expQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    words = '{8'h11, 8'h22};
    applyStimulus(words, -1, 0, 8'h00, misoQ);
    checkOutput("ovr_hold_data", rx_data, 8'h11);
    checkOutput("ovr_after2", overrun, (2 > CAP) ? 1 : 0);
    words = '{8'h33, 8'h44, 8'h55};
    applyStimulus(words, -1, 0, 8'h00, misoQ);
    checkOutput("ovr_after5", overrun, (5 > CAP) ? 1 : 0);
    drain();
    checkOutput("ovr_kept", gotQ.size(), CAP);
    for (int k = 0; k < CAP; k++)
      checkOutput($sformatf("ovr_word%0d", k), (gotQ.size() > k) ? gotQ[k] : 8'hxx, expQ[k]);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    checkOutput("ovr_cleared", overrun, 0);

    // Partial word discarded on CS rise.
    gotQ.delete();
    rx_ready = 1'b1;
    cs = 1'b0;
    spiBits(5);
    endFrame();
    checkOutput("partial_none", gotQ.size(), 0);
    words = '{8'hF0};
    applyStimulus(words, -1, 0, 8'h00, misoQ);
    tick(4);
    rx_ready = 1'b0;
    checkOutput("partial_next_count", gotQ.size(), 1);
    checkOutput("partial_next_data", (gotQ.size() > 0) ? gotQ[0] : 8'hxx, 8'hF0);
    checkOutput("partial_overrun", overrun, 0);

    // Reset mid-word with CS held low.
    loadReply(8'hFF);
    cs = 1'b0;
    spiBits(3);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_miso", miso, 0);
    checkOutput("midrst_rx_data", rx_data, 0);
    checkOutput("midrst_rx_valid", rx_valid, 0);
    checkOutput("midrst_overrun", overrun, 0);
    checkOutput("midrst_frame_active", frame_active, 0);
    tick(2);
    reset_n = 1'b1;
    spiBits(5);
    spiWord(8'h7E, m, 0, 8'h00);
    tick(HALF);
    checkOutput("midrst_no_word", rx_valid, 0);
    checkOutput("midrst_miso_quiet", m, 8'h00);
    cs = 1'b1;
    tick(2 * HALF);
    words = '{8'h7E};
    applyStimulus(words, -1, 0, 8'h00, misoQ);
    checkOutput("midrst_fresh_valid", rx_valid, 1);
    checkOutput("midrst_fresh_data", rx_data, 8'h7E);
    drain();

    // Completion while full with coincident rx_ready, then clear coincident with a new overrun.
    gotQ.delete();
    words = '{8'h10};
    applyStimulus(words, -1, 0, 8'h00, misoQ);
    words = '{8'h20};
    applyStimulus(words, 0, 2, 8'h00, misoQ);
    checkOutput("coin_data", rx_data, 8'h20);
    checkOutput("coin_valid", rx_valid, 1);
    checkOutput("coin_overrun", overrun, 0);
    checkOutput("coin_popped_old", (gotQ.size() > 0) ? gotQ[0] : 8'hxx, 8'h10);
    words.delete();
    for (int k = 1; k < CAP; k++) words.push_back(8'h30 + 8'(k));
    if (words.size() > 0) applyStimulus(words, -1, 0, 8'h00, misoQ);
    words = '{8'h40};
    applyStimulus(words, 0, 3, 8'h00, misoQ);
    checkOutput("clr_vs_set", overrun, 1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    checkOutput("clr_alone", overrun, 0);
    drain();

    // Random frames against a queue model of the link.
    replyModel = 8'hFF;
    loadReply(replyModel);
    rx_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      gotQ.delete();
      expQ.delete();
      if ($urandom_range(1, 0) == 1) begin
        replyModel = 8'($urandom);
        loadReply(replyModel);
      end
      n = $urandom_range(3, 1);
      cs = 1'b0;
      for (int k = 0; k < n; k++) begin
        expQ.push_back(8'($urandom));
        spiWord(expQ[k], m, 0, 8'h00);
        checkOutput($sformatf("rand%0d_miso%0d", f, k), m, replyModel);
      end
      if ($urandom_range(3, 0) == 0) spiBits($urandom_range(DW - 1, 1));
      endFrame();
      checkOutput($sformatf("rand%0d_count", f), gotQ.size(), expQ.size());
      for (int k = 0; k < expQ.size(); k++)
        checkOutput($sformatf("rand%0d_rx%0d", f, k), (gotQ.size() > k) ? gotQ[k] : 8'hxx, expQ[k]);
    end
    rx_ready = 1'b0;
    checkOutput("rand_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
